// File: rtl/stn_capture_if.sv
// stn_capture_if: write port from the STN capture stage to the dual-bank
// nibble frame buffer, plus the scan-out bank hand-off.
//
// Handshake: this port is valid-only. A nonzero wr_ce marks wr_block,
// wr_addr and wr_data as valid for exactly that one cycle. There is no
// ready signal and the producer never stalls, so the consumer must accept
// every cycle in which wr_ce is nonzero. rd_bank is a level. frame_done
// pulses for one cycle in the same cycle that rd_bank takes its new value.
interface stn_capture_if;
    logic [1:0]  wr_ce;
    logic [2:0]  wr_block;
    logic [11:0] wr_addr;
    logic [3:0]  wr_data;
    logic        rd_bank;
    logic        frame_done;

    modport master (
        output wr_ce, wr_block, wr_addr, wr_data, rd_bank, frame_done
    );

    modport slave (
        input wr_ce, wr_block, wr_addr, wr_data, rd_bank, frame_done
    );
endinterface

// File: rtl/stn_capture.sv
// stn_capture: oversamples the STN panel bus (FLM/CL1/CL2/D) and turns every
// CL2 falling edge inside an active frame into one nibble write. Lines and
// frames are counted to form block/address pairs. Completed frames swap the
// write bank and hand the finished bank to the scan-out side.
//
// Optional feature macro: STN_CAPTURE_GLITCH_EN
//   defined   - CL1/CL2 edges must hold their new synced level for two
//               cycles before being accepted; latency grows by one cycle.
//   undefined - raw synchronized edges.
module stn_capture #(
    parameter int H_NIBBLES = 80,
    parameter int V_LINES   = 240
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stn_flm,
    input  logic          stn_cl1,
    input  logic          stn_cl2,
    input  logic [3:0]    stn_d,
    stn_capture_if.master wr,
    output logic          err_line,
    output logic          err_frame,
    output logic          dbg_state
);

    localparam int NIB_W  = $clog2(H_NIBBLES + 2);
    localparam int LINE_W = $clog2(V_LINES + 2);

    localparam logic [NIB_W-1:0]  NIB_FULL  = NIB_W'(H_NIBBLES);
    localparam logic [NIB_W-1:0]  NIB_SAT   = NIB_W'(H_NIBBLES + 1);
    localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_LINES);
    localparam logic [LINE_W-1:0] LINE_SAT  = LINE_W'(V_LINES + 1);
    localparam logic [14:0]       LINE_STEP = 15'(H_NIBBLES);

    // The linear nibble index is 15 bits wide; larger frames cannot be addressed.
    if (H_NIBBLES * V_LINES > 32768) begin : g_size_check
        $error("stn_capture: H_NIBBLES*V_LINES exceeds 32768");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronizer vectors are packed as {flm, cl1, cl2, d[3:0]}.
    logic [6:0] sync1;
    logic [6:0] sync2;
    logic       cl1_s3;
    logic       cl2_s3;

    // Combinational edge/level taps aligned with each other.
    logic       cl1_fall_c;
    logic       cl2_fall_c;
    logic       flm_c;
    logic [3:0] d_c;

    // Registered edge pulses with their aligned FLM level and nibble.
    logic       cl1_p;
    logic       cl2_p;
    logic       flm_p;
    logic [3:0] nib_p;

    // Frame tracking state.
    state_t              state_q;
    state_t              state_d;
    logic                wr_sel;
    logic [14:0]         ptr;
    logic [14:0]         line_base;
    logic [NIB_W-1:0]    nib_cnt;
    logic [LINE_W-1:0]   line_cnt;

    // Decoded events for the current cycle.
    logic              frame_start;
    logic              line_end;
    logic              shift;
    logic              do_write;
    logic              frame_ok;
    logic              frame_bad;
    logic              line_short;
    logic [NIB_W-1:0]  nib_after;

    // Two-flop synchronizer on every panel input plus one history flop per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cl1_s3 <= 1'b0;
            cl2_s3 <= 1'b0;
        end else begin
            sync1  <= {stn_flm, stn_cl1, stn_cl2, stn_d};
            sync2  <= sync1;
            cl1_s3 <= sync2[5];
            cl2_s3 <= sync2[4];
        end
    end

`ifdef STN_CAPTURE_GLITCH_EN
    logic       flm_s3;
    logic [3:0] d_s3;
    logic       cl1_filt;
    logic       cl2_filt;

    // Filtered CL levels only follow the synced level once it has held two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            flm_s3   <= 1'b0;
            d_s3     <= '0;
            cl1_filt <= 1'b0;
            cl2_filt <= 1'b0;
        end else begin
            flm_s3   <= sync2[6];
            d_s3     <= sync2[3:0];
            cl1_filt <= (sync2[5] == cl1_s3) ? sync2[5] : cl1_filt;
            cl2_filt <= (sync2[4] == cl2_s3) ? sync2[4] : cl2_filt;
        end
    end

    // A fall is accepted when the filtered level is high and low has held two cycles.
    always_comb begin
        cl1_fall_c = cl1_filt & ~cl1_s3 & ~sync2[5];
        cl2_fall_c = cl2_filt & ~cl2_s3 & ~sync2[4];
        flm_c      = flm_s3;
        d_c        = d_s3;
    end
`else
    // Raw synchronized falling edges; data and FLM tapped at the matching stage.
    always_comb begin
        cl1_fall_c = cl1_s3 & ~sync2[5];
        cl2_fall_c = cl2_s3 & ~sync2[4];
        flm_c      = sync2[6];
        d_c        = sync2[3:0];
    end
`endif

    // Register edge pulses together with the nibble sampled at the CL2 fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            cl1_p <= 1'b0;
            cl2_p <= 1'b0;
            flm_p <= 1'b0;
            nib_p <= '0;
        end else begin
            cl1_p <= cl1_fall_c;
            cl2_p <= cl2_fall_c;
            flm_p <= flm_c;
            nib_p <= d_c;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any FLM frame start enters ACTIVE; only reset leaves it.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ACTIVE;
        end
    end

    // FSM outputs: decode write, line-end and frame-start events for this cycle.
    always_comb begin
        frame_start = cl1_p & flm_p;
        line_end    = cl1_p & ~flm_p & (state_q == ACTIVE);
        shift       = cl2_p & (state_q == ACTIVE);
        do_write    = shift & (nib_cnt < NIB_FULL) & (line_cnt < LINE_FULL);
        nib_after   = nib_cnt;
        if (shift && (nib_cnt != NIB_SAT)) begin
            nib_after = nib_cnt + NIB_W'(1);
        end
        frame_ok    = frame_start & (state_q == ACTIVE) & (line_cnt == LINE_FULL);
        frame_bad   = frame_start & (state_q == ACTIVE) & (line_cnt != LINE_FULL);
        // The same-cycle nibble counts toward this line before the length check.
        line_short  = line_end & (line_cnt < LINE_FULL) & (nib_after != NIB_FULL);
    end

    // Datapath: registered write port, bank swap, error flags and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr.wr_ce      <= 2'b00;
            wr.wr_block   <= '0;
            wr.wr_addr    <= '0;
            wr.wr_data    <= '0;
            wr.rd_bank    <= 1'b1;
            wr.frame_done <= 1'b0;
            err_line      <= 1'b0;
            err_frame     <= 1'b0;
            wr_sel        <= 1'b0;
            ptr           <= '0;
            line_base     <= '0;
            nib_cnt       <= '0;
            line_cnt      <= '0;
        end else begin
            wr.wr_ce <= do_write ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
            if (do_write) begin
                wr.wr_block <= ptr[14:12];
                wr.wr_addr  <= ptr[11:0];
                wr.wr_data  <= nib_p;
            end

            wr.frame_done <= frame_ok;
            if (frame_ok) begin
                wr.rd_bank <= wr_sel;
                wr_sel     <= ~wr_sel;
            end
            if (frame_bad) begin
                err_frame <= 1'b1;
            end
            if (line_short) begin
                err_line <= 1'b1;
            end

            // The nibble at the current ptr is issued above; line/frame updates win here.
            if (frame_start) begin
                ptr       <= '0;
                line_base <= '0;
                nib_cnt   <= '0;
                line_cnt  <= '0;
            end else if (line_end) begin
                line_base <= line_base + LINE_STEP;
                ptr       <= line_base + LINE_STEP;
                nib_cnt   <= '0;
                line_cnt  <= (line_cnt == LINE_SAT) ? line_cnt : line_cnt + LINE_W'(1);
            end else begin
                if (do_write) begin
                    ptr <= ptr + 15'd1;
                end
                nib_cnt <= nib_after;
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_stn_capture.sv
// tb_stn_capture: directed bench for stn_capture. Panel-side waveforms are
// driven from tasks on the falling clock edge; the write port is captured on
// the falling edge and compared in order against a queue of expected writes
// built from a line/nibble address model.
module tb_stn_capture;

    localparam int H = 80;
    localparam int V = 240;
`ifdef STN_CAPTURE_GLITCH_EN
    localparam int LAT      = 4;
    localparam int CL2_LOW  = 3;
    localparam int CL2_HIGH = 3;
`else
    localparam int LAT      = 3;
    localparam int CL2_LOW  = 2;
    localparam int CL2_HIGH = 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       stn_flm;
    logic       stn_cl1;
    logic       stn_cl2;
    logic [3:0] stn_d;
    logic       err_line;
    logic       err_frame;
    logic       dbg_state;

    stn_capture_if wr_if ();

    stn_capture #(.H_NIBBLES(H), .V_LINES(V)) dut (
        .clk       (clk),
        .rst       (rst),
        .stn_flm   (stn_flm),
        .stn_cl1   (stn_cl1),
        .stn_cl2   (stn_cl2),
        .stn_d     (stn_d),
        .wr        (wr_if),
        .err_line  (err_line),
        .err_frame (err_frame),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];
    int          obs_rd = 0;
    int          fd_count = 0;
    logic        exp_bank = 1'b0;

    typedef struct {
        int shifts;
        bit same;
        bit exp_err;
    } line_vec_t;

    line_vec_t vec[5];

    // Capture every write and frame_done pulse away from the active edge.
    always @(negedge clk) begin
        if (wr_if.wr_ce != 2'b00) begin
            obs_q.push_back({wr_if.wr_ce, wr_if.wr_block, wr_if.wr_addr, wr_if.wr_data});
        end
        if (wr_if.frame_done) begin
            fd_count = fd_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int p, input logic [3:0] d);
        logic [14:0] p15;
        p15 = 15'(p);
        exp_q.push_back({(exp_bank ? 2'b10 : 2'b01), p15[14:12], p15[11:0], d});
    endtask

    task automatic drain(input string name);
        while (obs_rd < obs_q.size()) begin
            if (exp_q.size() == 0) begin
                chk({name, " unexpected write"}, 32'(obs_q[obs_rd]), 32'd0);
            end else begin
                chk(name, 32'(obs_q[obs_rd]), 32'(exp_q.pop_front()));
            end
            obs_rd++;
        end
        chk({name, " missing writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset(input string name);
        chk({name, " wr_ce"}, 32'(wr_if.wr_ce), 0);
        chk({name, " wr_block"}, 32'(wr_if.wr_block), 0);
        chk({name, " wr_addr"}, 32'(wr_if.wr_addr), 0);
        chk({name, " wr_data"}, 32'(wr_if.wr_data), 0);
        chk({name, " rd_bank"}, 32'(wr_if.rd_bank), 1);
        chk({name, " frame_done"}, 32'(wr_if.frame_done), 0);
        chk({name, " err_line"}, 32'(err_line), 0);
        chk({name, " err_frame"}, 32'(err_frame), 0);
        chk({name, " state"}, 32'(dbg_state), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic shift(input logic [3:0] d);
        stn_d   = d;
        stn_cl2 = 1'b0;
        tick(CL2_LOW);
        stn_cl2 = 1'b1;
        tick(CL2_HIGH);
    endtask

    task automatic line_end();
        stn_cl1 = 1'b1;
        tick(3);
        stn_cl1 = 1'b0;
        tick(LAT + 2);
    endtask

    task automatic frame_start(output int fd_k, output logic rd_before, output logic rd_at_fd);
        stn_flm = 1'b1;
        tick(3);
        stn_cl1 = 1'b1;
        tick(3);
        stn_cl1   = 1'b0;
        fd_k      = -1;
        rd_before = 1'bx;
        rd_at_fd  = 1'bx;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == LAT - 1) rd_before = wr_if.rd_bank;
            if (wr_if.frame_done && fd_k < 0) begin
                fd_k     = k;
                rd_at_fd = wr_if.rd_bank;
            end
        end
        stn_flm = 1'b0;
        tick(2);
    endtask

    // One panel line: n shifts, optionally with the last shift coincident with CL1's fall.
    task automatic run_line(input int line, input int n, input bit same);
        logic [3:0] d;
        for (int j = 0; j < n; j++) begin
            d = 4'(line * 5 + j);
            if (j < H && line < V) push_exp(line * H + j, d);
            if (same && j == n - 1) begin
                stn_cl1 = 1'b1;
                tick(3);
                stn_d   = d;
                stn_cl2 = 1'b0;
                stn_cl1 = 1'b0;
                tick(CL2_LOW);
                stn_cl2 = 1'b1;
                tick(CL2_HIGH + LAT + 2);
            end else begin
                shift(d);
            end
        end
        if (!same) line_end();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int   fd_k;
        int   base;
        logic rd_before;
        logic rd_at_fd;
        logic [20:0] last_w;

        vec[0] = '{shifts: 80, same: 1'b0, exp_err: 1'b0};
        vec[1] = '{shifts: 80, same: 1'b1, exp_err: 1'b0};
        vec[2] = '{shifts: 79, same: 1'b0, exp_err: 1'b1};
        vec[3] = '{shifts: 85, same: 1'b0, exp_err: 1'b1};
        vec[4] = '{shifts: 80, same: 1'b0, exp_err: 1'b1};

        rst     = 1'b1;
        stn_flm = 1'b0;
        stn_cl1 = 1'b0;
        stn_cl2 = 1'b1;
        stn_d   = 4'h0;
        tick(3);
        check_reset("reset");
        rst = 1'b0;
        tick(5);

        // IDLE: shifts and a plain line end do nothing.
        shift(4'h3);
        shift(4'h4);
        line_end();
        drain("idle writes");
        chk("idle state", 32'(dbg_state), 0);
        chk("idle err_line", 32'(err_line), 0);

        // First FLM from IDLE: no swap, no error.
        frame_start(fd_k, rd_before, rd_at_fd);
        chk("first flm frame_done", 32'(fd_k), 32'(-1));
        chk("first flm state", 32'(dbg_state), 1);
        chk("first flm err_frame", 32'(err_frame), 0);

        // Write latency for D=0xA, cycle by cycle.
        push_exp(0, 4'hA);
        stn_d   = 4'hA;
        stn_cl2 = 1'b0;
        for (int k = 0; k <= LAT + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("latency k=%0d wr_ce", k), 32'(wr_if.wr_ce), (k == LAT) ? 1 : 0);
        end
        stn_cl2 = 1'b1;
        tick(CL2_HIGH);
        push_exp(1, 4'h5);
        shift(4'h5);
        tick(LAT + 2);
        drain("latency writes");

        // Reset mid-frame clears outputs; later CL2 activity without FLM writes nothing.
        rst = 1'b1;
        tick(1);
        check_reset("midframe reset");
        rst = 1'b0;
        tick(5);
        shift(4'h6);
        shift(4'h7);
        tick(LAT + 2);
        drain("post reset writes");
        chk("post reset state", 32'(dbg_state), 0);

        // Line-length vectors inside a fresh frame.
        frame_start(fd_k, rd_before, rd_at_fd);
        chk("frame2 start frame_done", 32'(fd_k), 32'(-1));
        for (int i = 0; i < 5; i++) begin
            run_line(i, vec[i].shifts, vec[i].same);
            chk($sformatf("line %0d err_line", i), 32'(err_line), 32'(vec[i].exp_err));
            drain($sformatf("line %0d writes", i));
        end
        for (int i = 5; i < 100; i++) line_end();

        // FLM after 100 lines: frame error, no swap, same bank rewritten from 0.
        frame_start(fd_k, rd_before, rd_at_fd);
        chk("short frame frame_done", 32'(fd_k), 32'(-1));
        chk("short frame err_frame", 32'(err_frame), 1);
        chk("short frame rd_bank", 32'(wr_if.rd_bank), 1);
        for (int j = 0; j < 3; j++) begin
            push_exp(j, 4'(9 + j));
            shift(4'(9 + j));
        end
        tick(LAT + 2);
        drain("rewrite writes");

        // Full 80x240 frame from a clean reset.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        frame_start(fd_k, rd_before, rd_at_fd);
        base = obs_q.size();
        for (int i = 0; i < V; i++) run_line(i, H, 1'b0);
        chk("full frame write count", 32'(obs_q.size() - base), 32'd19200);
        last_w = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 21'h0;
        chk("full frame last block/addr", 32'(last_w[18:4]), 32'h4AFF);
        chk("full frame last ce", 32'(last_w[20:19]), 1);
        drain("full frame writes");

        base = fd_count;
        frame_start(fd_k, rd_before, rd_at_fd);
        chk("swap frame_done latency", 32'(fd_k), 32'(LAT));
        chk("swap frame_done pulses", 32'(fd_count - base), 1);
        chk("swap rd_bank before", 32'(rd_before), 1);
        chk("swap rd_bank at pulse", 32'(rd_at_fd), 0);
        chk("swap rd_bank after", 32'(wr_if.rd_bank), 0);
        chk("swap err_frame", 32'(err_frame), 0);
        chk("swap err_line", 32'(err_line), 0);

        // Next frame writes land in bank 1.
        exp_bank = 1'b1;
        push_exp(0, 4'hC);
        shift(4'hC);
        push_exp(1, 4'hD);
        shift(4'hD);
        tick(LAT + 2);
        drain("bank1 writes");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
